fifo_burst_writer: RTL and testbench

- Write-side producer stage that feeds the asynchronous FIFO write port in the `wclk` domain.
- Accepts a burst command (length N), then forwards exactly N bytes from a valid/ready byte source into the FIFO, asserting `winc` only when the FIFO is not full.
- Tags each burst with an incrementing burst ID, matching the `Burst_ID` field carried on the write interface, for scoreboard correlation.
- Reports completion, command errors and full-stall cycles.

---
 rtl/fifo_burst_writer.sv | 101 ++++++++++
 tb/tb_fifo_burst_writer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_writer.sv
// Purpose: write-side producer that pushes exactly cmd_len source bytes per burst into an async FIFO, tagging each burst with an ID.
// Latency: first write can land one cycle after command acceptance; one byte per cycle thereafter, done pulses the cycle after the last write.
// Backpressure: wfull blocks winc and src_ready combinationally in the same cycle; a low src_valid simply holds the burst.
module fifo_burst_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 64,
    parameter int LEN_W      = 7,
    parameter int ID_WIDTH   = 32
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  winc,
    input  logic                  wfull,
    output logic [ID_WIDTH-1:0]   burst_id,
    output logic                  busy,
    output logic                  done,
    output logic                  cmd_err,
    output logic [15:0]           stall_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic             len_legal;

    // A command length is usable only when it is non-zero and fits within the largest burst.
    always_comb begin
        len_legal = (cmd_len != '0) && (cmd_len <= LEN_W'(MAX_BURST));
    end

    // Write strobe and source handshake stay combinational so a freshly raised wfull blocks the write in the same cycle.
    always_comb begin
        src_ready = (state == BURST) && !wfull;
        winc      = (state == BURST) && src_valid && !wfull;
        wdata     = src_data;
    end

    // Burst sequencer: command intake, byte countdown, ID tagging, status pulses and stall accounting.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state     <= IDLE;
            remaining <= '0;
            burst_id  <= '0;
            stall_cnt <= '0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            done    <= 1'b0;
            cmd_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (len_legal) begin
                            remaining <= cmd_len;
                            burst_id  <= burst_id + ID_WIDTH'(1);
                            state     <= BURST;
                            busy      <= 1'b1;
                            cmd_ready <= 1'b0;
                        end else begin
                            // Illegal length: handshake completes but nothing is launched.
                            cmd_err <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (wfull && (stall_cnt != 16'hFFFF)) begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                    if (winc) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            cmd_ready <= 1'b1;
                            done      <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Purpose: directed bench for fifo_burst_writer with a queue-based scoreboard for writes, done and cmd_err.
// Latency: expectations are queued by the stimulus and consumed by a negedge monitor whenever the DUT strobes an output.
// Backpressure: wfull is driven directly by the stimulus to exercise full stalls.
module tb_fifo_burst_writer;

    localparam int DW  = 8;
    localparam int MB  = 64;
    localparam int LW  = 7;
    localparam int IDW = 4;

    typedef struct packed {
        logic [DW-1:0]  d;
        logic [IDW-1:0] id;
    } wr_t;

    logic           wclk;
    logic           wrst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [LW-1:0]  cmd_len;
    logic           src_valid;
    logic           src_ready;
    logic [DW-1:0]  src_data;
    logic [DW-1:0]  wdata;
    logic           winc;
    logic           wfull;
    logic [IDW-1:0] burst_id;
    logic           busy;
    logic           done;
    logic           cmd_err;
    logic [15:0]    stall_cnt;

    int checks   = 0;
    int failures = 0;

    wr_t            wq[$];
    logic [IDW-1:0] done_q[$];
    int             pending_err = 0;
    int             err_seen    = 0;
    int             done_seen   = 0;
    int             wr_seen     = 0;
    int             cyc         = 0;
    int             last_wr_cyc = -10;
    logic [IDW-1:0] exp_id      = '0;

    fifo_burst_writer #(
        .DATA_WIDTH(DW),
        .MAX_BURST (MB),
        .LEN_W     (LW),
        .ID_WIDTH  (IDW)
    ) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_len  (cmd_len),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .src_data (src_data),
        .wdata    (wdata),
        .winc     (winc),
        .wfull    (wfull),
        .burst_id (burst_id),
        .busy     (busy),
        .done     (done),
        .cmd_err  (cmd_err),
        .stall_cnt(stall_cnt)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: consume scoreboard entries whenever the DUT strobes an output.
    initial begin
        wr_t e;
        logic [IDW-1:0] di;
        forever begin
            @(negedge wclk);
            cyc++;
            if (winc === 1'b1) begin
                wr_seen++;
                last_wr_cyc = cyc;
                if (wq.size() == 0) begin
                    check("winc_unexpected", {24'd0, wdata}, 32'hFFFF_FFFF);
                end else begin
                    e = wq.pop_front();
                    check("wdata", {24'd0, wdata}, {24'd0, e.d});
                    check("wr_burst_id", {28'd0, burst_id}, {28'd0, e.id});
                end
            end
            if (done === 1'b1) begin
                done_seen++;
                if (done_q.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    di = done_q.pop_front();
                    check("done_burst_id", {28'd0, burst_id}, {28'd0, di});
                    check("done_after_last_write", cyc - last_wr_cyc, 32'd1);
                end
            end
            if (cmd_err === 1'b1) begin
                err_seen++;
                check("cmd_err_expected", (pending_err > 0) ? 32'd1 : 32'd0, 32'd1);
                if (pending_err > 0) pending_err--;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(posedge wclk);
        #1;
        wrst = 1'b1;
        exp_id = '0;
        #1;
        check("rst_winc", {31'd0, winc}, 32'd0);
        check("rst_src_ready", {31'd0, src_ready}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_burst_id", {28'd0, burst_id}, 32'd0);
        check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        @(posedge wclk);
        #1;
        wrst = 1'b0;
    endtask

    task automatic send_cmd(input int len, input bit legal);
        int n;
        logic [31:0] lv;
        n = 0;
        lv = len;
        cmd_valid = 1'b1;
        cmd_len = lv[LW-1:0];
        @(negedge wclk);
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge wclk);
            n++;
        end
        if (n >= 100) check("cmd_ready_timeout", 32'd0, 32'd1);
        @(posedge wclk);
        #1;
        cmd_valid = 1'b0;
        if (legal) begin
            exp_id = exp_id + 4'd1;
            check("busy_after_cmd", {31'd0, busy}, 32'd1);
            check("id_after_cmd", {28'd0, burst_id}, {28'd0, exp_id});
        end else begin
            pending_err++;
            check("idle_after_bad_cmd", {31'd0, busy}, 32'd0);
            check("id_kept_after_bad_cmd", {28'd0, burst_id}, {28'd0, exp_id});
        end
    endtask

    task automatic send_byte(input logic [DW-1:0] b, input bit last);
        int n;
        n = 0;
        wq.push_back('{d: b, id: exp_id});
        if (last) done_q.push_back(exp_id);
        src_valid = 1'b1;
        src_data = b;
        @(negedge wclk);
        while (src_ready !== 1'b1 && n < 100) begin
            @(negedge wclk);
            n++;
        end
        if (n >= 100) check("src_ready_timeout", 32'd0, 32'd1);
        @(posedge wclk);
        #1;
        src_valid = 1'b0;
    endtask

    initial begin
        int t_prev;
        int t_now;
        logic [DW-1:0] pat[4];
        wrst = 1'b0;
        cmd_valid = 1'b0;
        cmd_len = '0;
        src_valid = 1'b0;
        src_data = '0;
        wfull = 1'b0;
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;

        // Single burst of four bytes.
        do_reset();
        send_cmd(4, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(pat[i], i == 3);
        repeat (2) @(posedge wclk);
        #1;
        check("single_idle", {31'd0, busy}, 32'd0);

        // Full stall of five cycles after the first write.
        do_reset();
        send_cmd(3, 1'b1);
        send_byte(8'hA1, 1'b0);
        wfull = 1'b1;
        src_valid = 1'b1;
        src_data = 8'hA2;
        for (int i = 0; i < 5; i++) begin
            @(negedge wclk);
            check("stall_no_winc", {31'd0, winc}, 32'd0);
            check("stall_no_src_ready", {31'd0, src_ready}, 32'd0);
            @(posedge wclk);
            #1;
        end
        wfull = 1'b0;
        send_byte(8'hA2, 1'b0);
        send_byte(8'hA3, 1'b1);
        @(posedge wclk);
        #1;
        check("stall_cnt", {16'd0, stall_cnt}, 32'd5);

        // Illegal lengths with the source offering data.
        src_valid = 1'b1;
        src_data = 8'hEE;
        send_cmd(0, 1'b0);
        send_cmd(MB + 1, 1'b0);
        @(negedge wclk);
        check("bad_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("bad_src_ready", {31'd0, src_ready}, 32'd0);
        @(posedge wclk);
        #1;
        src_valid = 1'b0;

        // Seventeen back-to-back single-byte bursts; 4-bit ID wraps.
        do_reset();
        t_prev = 0;
        for (int k = 0; k < 17; k++) begin
            send_cmd(1, 1'b1);
            t_now = $time;
            check("wrap_id", {28'd0, burst_id}, (k + 1) % 16);
            if (k > 0) check("b2b_spacing", t_now - t_prev, 32'd20);
            t_prev = t_now;
            send_byte(8'(8'h40 + k), 1'b1);
        end

        // Reset in the middle of an eight-byte burst.
        send_cmd(8, 1'b1);
        send_byte(8'h71, 1'b0);
        send_byte(8'h72, 1'b0);
        src_valid = 1'b1;
        src_data = 8'h73;
        #2;
        check("winc_before_rst", {31'd0, winc}, 32'd1);
        wrst = 1'b1;
        exp_id = '0;
        #1;
        check("midrst_winc", {31'd0, winc}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_id", {28'd0, burst_id}, 32'd0);
        check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        src_valid = 1'b0;
        send_cmd(2, 1'b1);
        send_byte(8'h81, 1'b0);
        send_byte(8'h82, 1'b1);

        // Maximum burst with the source valid every other cycle.
        send_cmd(MB, 1'b1);
        for (int i = 0; i < MB; i++) begin
            send_byte(8'(i * 3 + 1), i == MB - 1);
            @(posedge wclk);
            #1;
        end
        src_valid = 1'b1;
        src_data = 8'hFF;
        repeat (3) @(posedge wclk);
        #1;
        src_valid = 1'b0;
        check("max_idle", {31'd0, busy}, 32'd0);

        repeat (3) @(posedge wclk);
        #1;
        check("writes_left", wq.size(), 32'd0);
        check("dones_left", done_q.size(), 32'd0);
        check("errs_left", pending_err, 32'd0);
        check("err_total", err_seen, 32'd2);
        check("done_total", done_seen, 32'd21);
        check("write_total", wr_seen, 32'd92);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
